// File: rtl/frame_minmax_seq.sv
// frame_minmax_seq: per-frame min/max tracker sharing one external 6-bit comparator
`timescale 1ns/1ps
module frame_minmax_seq #(
  parameter int FRAME_LEN = 4,
  parameter int SETTLE_CYCLES = 1,
  localparam int IDX_W = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [5:0]       in_data,
  output logic             in_ready,
  output logic [5:0]       cmp_a,
  output logic [5:0]       cmp_b,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  output logic             frame_done,
  output logic [5:0]       res_max,
  output logic [5:0]       res_min,
  output logic [IDX_W-1:0] max_idx,
  output logic [IDX_W-1:0] min_idx,
  output logic             cmp_err
);
  typedef enum logic [1:0] {IDLE, CMP_MAX, CMP_MIN, DONE} state_t;
  state_t state, state_nxt;
  logic [IDX_W-1:0] idx, run_max_idx, run_min_idx, cmin_idx;
  logic [5:0] run_max, run_min, cmin;
  logic [2:0] cnt;
  logic acc, first, last, fin, max_up, min_up;
  assign acc = state == IDLE && in_valid;
  assign first = acc && idx == '0;
  assign last = cnt == 3'(SETTLE_CYCLES);
  assign fin = idx == IDX_W'(FRAME_LEN - 1);
  assign max_up = state == CMP_MAX && last && cmp_gt;
  assign min_up = state == CMP_MIN && last && cmp_lt;
  assign cmin = min_up ? cmp_a : run_min;
  assign cmin_idx = min_up ? idx : run_min_idx;
  // next-state: each compare phase holds for SETTLE_CYCLES+1 cycles
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = acc && !first ? CMP_MAX : IDLE;
      CMP_MAX: state_nxt = last ? CMP_MIN : CMP_MAX;
      CMP_MIN: state_nxt = last ? (fin ? DONE : IDLE) : CMP_MIN;
      default: state_nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // registered outputs, running extremes and frame results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b1;
      frame_done <= 1'b0;
      cmp_a <= '0;
      cmp_b <= '0;
      cnt <= '0;
      idx <= '0;
      run_max <= '0;
      run_min <= '0;
      run_max_idx <= '0;
      run_min_idx <= '0;
      res_max <= '0;
      res_min <= '0;
      max_idx <= '0;
      min_idx <= '0;
      cmp_err <= 1'b0;
    end else begin
      in_ready <= state_nxt == IDLE;
      frame_done <= state_nxt == DONE;
      cnt <= state_nxt == state && state != IDLE ? cnt + 3'd1 : '0;
      cmp_a <= state_nxt == IDLE || state_nxt == DONE ? '0 : acc ? in_data : cmp_a;
      cmp_b <= state_nxt == CMP_MAX ? run_max : state_nxt == CMP_MIN ? run_min : '0;
      run_max <= first ? in_data : max_up ? cmp_a : run_max;
      run_max_idx <= first ? '0 : max_up ? idx : run_max_idx;
      run_min <= first ? in_data : cmin;
      run_min_idx <= first ? '0 : cmin_idx;
      idx <= state == DONE ? '0 : first || (state == CMP_MIN && last && !fin) ? idx + 1'b1 : idx;
      cmp_err <= cmp_err | ((state == CMP_MAX || state == CMP_MIN) && last && !$onehot({cmp_gt, cmp_lt, cmp_eq}));
      if (state == CMP_MIN && last && fin) begin
        res_max <= run_max;
        max_idx <= run_max_idx;
        res_min <= cmin;
        min_idx <= cmin_idx;
      end
    end
  end
endmodule

// File: tb/tb_frame_minmax_seq.sv
// tb_frame_minmax_seq: directed checks of frame_minmax_seq against a behavioural comparator
`timescale 1ns/1ps
module tb_frame_minmax_seq;
  logic clk = 0, rst, in_valid, in_ready, cmp_gt, cmp_lt, cmp_eq, frame_done, cmp_err, force_bad;
  logic [5:0] in_data, cmp_a, cmp_b, res_max, res_min;
  logic [1:0] max_idx, min_idx;
  int checks = 0, errors = 0, pulses = 0, p;
  logic [5:0] nxt [3] = '{6'd2, 6'd8, 6'd0};
  frame_minmax_seq #(.FRAME_LEN(4), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
    .frame_done(frame_done), .res_max(res_max), .res_min(res_min),
    .max_idx(max_idx), .min_idx(min_idx), .cmp_err(cmp_err)
  );
  always #20 clk = ~clk;
  assign cmp_gt = force_bad | (cmp_a > cmp_b);
  assign cmp_lt = force_bad | (cmp_a < cmp_b);
  assign cmp_eq = !force_bad & (cmp_a == cmp_b);
  always @(posedge clk) if (frame_done === 1'b1) pulses++;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [5:0] v);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("send_wait", 8'(n < 50), 8'd1);
    in_valid = 1; in_data = v;
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (frame_done !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("done_wait", 8'(frame_done), 8'd1);
  endtask
  task automatic frame(input logic [5:0] a, b, c, d);
    send(a); send(b); send(c); send(d);
    wait_done();
  endtask
  task automatic res_chk(input string tag, input logic [5:0] mx, input logic [1:0] mxi, input logic [5:0] mn, input logic [1:0] mni);
    chk({tag, "_max"}, 8'(res_max), 8'(mx));
    chk({tag, "_max_idx"}, 8'(max_idx), 8'(mxi));
    chk({tag, "_min"}, 8'(res_min), 8'(mn));
    chk({tag, "_min_idx"}, 8'(min_idx), 8'(mni));
  endtask
  task automatic zero_chk(input string tag);
    res_chk(tag, 6'd0, 2'd0, 6'd0, 2'd0);
    chk({tag, "_ready"}, 8'(in_ready), 8'd1);
    chk({tag, "_done"}, 8'(frame_done), 8'd0);
    chk({tag, "_a"}, 8'(cmp_a), 8'd0);
    chk({tag, "_b"}, 8'(cmp_b), 8'd0);
    chk({tag, "_err"}, 8'(cmp_err), 8'd0);
  endtask
  initial begin
    rst = 0; in_valid = 0; in_data = 0; force_bad = 0;
    #5 rst = 1;
    #1 zero_chk("reset");
    @(negedge clk) rst = 0;
    p = pulses;
    frame(10, 50, 3, 50);
    res_chk("f1", 50, 1, 3, 2);
    @(negedge clk); @(negedge clk);
    chk("f1_pulses", 8'(pulses - p), 8'd1);
    frame(7, 7, 7, 7);
    res_chk("f2", 7, 0, 7, 0);
    frame(0, 63, 63, 0);
    res_chk("f3", 63, 1, 0, 0);
    frame(63, 0, 1, 62);
    res_chk("f4", 63, 0, 0, 1);
    @(negedge clk); @(negedge clk);
    in_valid = 1; in_data = 5;
    @(negedge clk);
    chk("s_first_ready", 8'(in_ready), 8'd1);
    in_data = 9;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (i == 0) in_data = nxt[k];
        chk("s_ready_low", 8'(in_ready), 8'd0);
      end
      if (k < 2) begin @(negedge clk); chk("s_ready_high", 8'(in_ready), 8'd1); end
    end
    chk("s_done_early", 8'(frame_done), 8'd0);
    @(negedge clk);
    in_valid = 0;
    chk("s_done_15", 8'(frame_done), 8'd1);
    res_chk("s", 9, 1, 2, 2);
    @(negedge clk); @(negedge clk);
    #5 rst = 1;
    #1 zero_chk("idle_rst");
    @(negedge clk) rst = 0;
    send(20); send(30);
    #5 rst = 1;
    #1 chk("mid_rst_ready", 8'(in_ready), 8'd1);
    chk("mid_rst_a", 8'(cmp_a), 8'd0);
    chk("mid_rst_b", 8'(cmp_b), 8'd0);
    @(negedge clk) rst = 0;
    frame(40, 1, 2, 3);
    res_chk("f5", 40, 0, 1, 1);
    send(10);
    force_bad = 1;
    send(20);
    @(negedge clk); @(negedge clk);
    force_bad = 0;
    chk("err_set", 8'(cmp_err), 8'd1);
    send(30); send(40);
    wait_done();
    chk("err_sticky", 8'(cmp_err), 8'd1);
    @(negedge clk);
    #5 rst = 1;
    #1 chk("err_clr", 8'(cmp_err), 8'd0);
    @(negedge clk) rst = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
